// File: rtl/spu_pkg.sv
// spu_pkg: shared pipe ids, issue FSM states and default widths for the SPU issue stage
package spu_pkg;
    localparam int ADDR_W_DEF = 7;
    localparam int LAT_W_DEF = 4;
    localparam logic PIPE_EVEN = 1'b0;
    localparam logic PIPE_ODD = 1'b1;
    typedef enum logic {PAIR, ODD_PEND} state_t;
endpackage

// File: rtl/spu_scoreboard.sv
// spu_scoreboard: per-register countdown of in-flight write latency with multi-port lookup
module spu_scoreboard
    import spu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LAT_W = LAT_W_DEF,
    parameter int NRD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ld_en,
    input  logic [2*ADDR_W-1:0]   ld_addr,
    input  logic [2*LAT_W-1:0]    ld_val,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*LAT_W-1:0]  rd_cnt
);
    logic [LAT_W-1:0] cnt [2**ADDR_W];
    for (genvar a = 0; a < 2**ADDR_W; a++) begin : g_ent
        logic hit0, hit1;
        assign hit0 = ld_en[0] && ld_addr[0 +: ADDR_W] == ADDR_W'(a);
        assign hit1 = ld_en[1] && ld_addr[ADDR_W +: ADDR_W] == ADDR_W'(a);
        // slot 1 is younger, so its load overrides slot 0 on the same register
        always_ff @(posedge clk)
            if (reset) cnt[a] <= '0;
            else cnt[a] <= hit1 ? ld_val[LAT_W +: LAT_W] : hit0 ? ld_val[0 +: LAT_W] : cnt[a] - LAT_W'(cnt[a] != '0);
    end
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign rd_cnt[r*LAT_W +: LAT_W] = cnt[rd_addr[r*ADDR_W +: ADDR_W]];
    end
endmodule

// File: rtl/spu_scoreboard_hazard.sv
// spu_scoreboard_hazard: dual-issue decision from a countdown scoreboard, with flush and stall counting
module spu_scoreboard_hazard
    import spu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LAT_W = LAT_W_DEF,
    parameter int FWD_LAT = 1,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          slot_valid,
    input  logic [1:0]          slot_pipe,
    input  logic [1:0]          slot_wr,
    input  logic [2*ADDR_W-1:0] slot_dst,
    input  logic [2*LAT_W-1:0]  slot_lat,
    input  logic [6*ADDR_W-1:0] slot_src,
    input  logic [5:0]          slot_src_v,
    input  logic                br_resolve,
    input  logic                br_mispredict,
    output logic [1:0]          issue,
    output logic                stall,
    output logic                flush,
    output logic [CNT_W-1:0]    stall_cnt
);
    state_t state, state_n;
    logic [8*LAT_W-1:0] rd_cnt;
    logic [LAT_W-1:0] lat_eff [2];
    logic [5:0] raw_src, dep_src;
    logic [1:0] hz;
    logic conflict;

    spu_scoreboard #(.ADDR_W(ADDR_W), .LAT_W(LAT_W), .NRD(8)) u_sb (
        .clk(clk),
        .reset(reset),
        .ld_en(issue & slot_wr),
        .ld_addr(slot_dst),
        .ld_val({lat_eff[1], lat_eff[0]}),
        .rd_addr({slot_dst, slot_src}),
        .rd_cnt(rd_cnt)
    );

    for (genvar i = 0; i < 6; i++) begin : g_src
        assign raw_src[i] = slot_src_v[i] && rd_cnt[i*LAT_W +: LAT_W] > LAT_W'(FWD_LAT);
        assign dep_src[i] = i >= 3 && slot_src_v[i] && slot_src[i*ADDR_W +: ADDR_W] == slot_dst[0 +: ADDR_W];
    end
    // a zero latency is illegal and behaves as a single-cycle result
    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign lat_eff[s] = slot_lat[s*LAT_W +: LAT_W] == '0 ? LAT_W'(1) : slot_lat[s*LAT_W +: LAT_W];
        assign hz[s] = slot_valid[s] && (|raw_src[3*s +: 3] ||
                       (slot_wr[s] && rd_cnt[(6+s)*LAT_W +: LAT_W] > lat_eff[s]));
    end
    assign conflict = &slot_valid && (slot_pipe[0] == slot_pipe[1] || (slot_wr[0] && |dep_src) ||
                      (&slot_wr && slot_dst[0 +: ADDR_W] == slot_dst[ADDR_W +: ADDR_W]));

    always_comb begin
        issue = 2'b00;
        stall = 1'b0;
        state_n = state;
        if (flush) state_n = PAIR;
        else if (!reset && state == PAIR) begin
            stall = hz[0] || conflict || hz[1];
            issue = hz[0] ? 2'b00 : stall ? {1'b0, slot_valid[0]} : slot_valid;
            state_n = !hz[0] && stall ? ODD_PEND : PAIR;
        end else if (!reset) begin
            stall = hz[1];
            issue = hz[1] ? 2'b00 : 2'b10;
            state_n = hz[1] ? ODD_PEND : PAIR;
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            state <= PAIR;
            flush <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            flush <= br_resolve && br_mispredict;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
endmodule
